// File: rtl/pool_fmap_if.sv
`default_nettype none
// ============================================================================
// Module   : pool_fmap_if
// Purpose  : Pooled-pixel input and channel-major output bus of the fmap reader.
// Revision : 1.0
// ============================================================================
interface pool_fmap_if #(
    parameter int CONV_BIT = 12
);
    logic                valid_in;
    logic [CONV_BIT-1:0] data_in_1;
    logic [CONV_BIT-1:0] data_in_2;
    logic [CONV_BIT-1:0] data_in_3;
    logic                ready_in;
    logic [CONV_BIT-1:0] data_out;
    logic                valid_out;
    logic                frame_done;
    logic                overflow;

    // Producer/consumer side (pooling stage plus next layer).
    modport master (
        output valid_in, data_in_1, data_in_2, data_in_3, ready_in,
        input  data_out, valid_out, frame_done, overflow
    );

    modport slave (
        input  valid_in, data_in_1, data_in_2, data_in_3, ready_in,
        output data_out, valid_out, frame_done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/pool_fmap_reader.sv
`default_nettype none
// ============================================================================
// Module   : pool_fmap_reader
// Purpose  : Buffers one 3-channel pooled frame, then drains it channel-major.
// Revision : 1.0
// ============================================================================
module pool_fmap_reader #(
    parameter int CONV_BIT    = 12,
    parameter int HALF_WIDTH  = 12,
    parameter int HALF_HEIGHT = 12,
    parameter int ADDR_BIT    = 8,
    parameter int CNT_BIT     = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    pool_fmap_if.slave  bus
);

    localparam int c_N     = HALF_WIDTH * HALF_HEIGHT;
    localparam int c_TOTAL = 3 * c_N;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CONV_BIT-1:0] r_bank1 [c_N];
    logic [CONV_BIT-1:0] r_bank2 [c_N];
    logic [CONV_BIT-1:0] r_bank3 [c_N];

    logic [ADDR_BIT-1:0] r_wr_ptr;
    logic [ADDR_BIT-1:0] r_rd_addr;
    logic [1:0]          r_rd_ch;
    logic [CNT_BIT-1:0]  r_rd_cnt;
    logic [CONV_BIT-1:0] r_data_out;
    logic                r_valid_out;
    logic                r_frame_done;
    logic                r_overflow;

    logic                w_wr_en;
    logic                w_wr_last;
    logic                w_xfer;
    logic                w_load;
    logic                w_end;
    logic [CONV_BIT-1:0] w_rd_word;

    assign w_wr_en   = (r_state == S_FILL) && bus.valid_in;
    assign w_wr_last = w_wr_en && (r_wr_ptr == ADDR_BIT'(c_N - 1));
    assign w_xfer    = r_valid_out && bus.ready_in;
    assign w_load    = (r_state == S_DRAIN) && (!r_valid_out || bus.ready_in)
                       && (r_rd_cnt < CNT_BIT'(c_TOTAL));
    // rd_cnt reaches 3N once the last word is loaded; its transfer ends the frame.
    assign w_end     = (r_state == S_DRAIN) && w_xfer
                       && (r_rd_cnt == CNT_BIT'(c_TOTAL));

    always_comb begin
        w_rd_word = r_bank3[r_rd_addr];
        case (r_rd_ch)
            2'd0:    w_rd_word = r_bank1[r_rd_addr];
            2'd1:    w_rd_word = r_bank2[r_rd_addr];
            default: w_rd_word = r_bank3[r_rd_addr];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_wr_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_end)     w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Storage carries no reset: contents are irrelevant until rewritten.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_bank1[r_wr_ptr] <= bus.data_in_1;
            r_bank2[r_wr_ptr] <= bus.data_in_2;
            r_bank3[r_wr_ptr] <= bus.data_in_3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FILL;
            r_wr_ptr     <= '0;
            r_rd_addr    <= '0;
            r_rd_ch      <= '0;
            r_rd_cnt     <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_end;

            if (bus.valid_in && (r_state == S_DRAIN))
                r_overflow <= 1'b1;

            if (w_wr_en)
                r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + ADDR_BIT'(1);

            if (w_wr_last || w_end) begin
                r_rd_cnt  <= '0;
                r_rd_ch   <= '0;
                r_rd_addr <= '0;
            end

            if (w_end) begin
                r_valid_out <= 1'b0;
            end else if (w_load) begin
                r_data_out  <= w_rd_word;
                r_valid_out <= 1'b1;
                r_rd_cnt    <= r_rd_cnt + CNT_BIT'(1);
                // Channel/address pair replaces rd_cnt / N and rd_cnt mod N.
                if (r_rd_addr == ADDR_BIT'(c_N - 1)) begin
                    r_rd_addr <= '0;
                    r_rd_ch   <= r_rd_ch + 2'd1;
                end else begin
                    r_rd_addr <= r_rd_addr + ADDR_BIT'(1);
                end
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.valid_out  = r_valid_out;
    assign bus.frame_done = r_frame_done;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pool_fmap_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_fmap_reader
// Purpose  : Table-driven and randomized checks of pool_fmap_reader vs a queue model.
// Revision : 1.0
// ============================================================================
module tb_pool_fmap_reader;

    localparam int CB    = 12;
    localparam int HW    = 12;
    localparam int HH    = 12;
    localparam int N     = HW * HH;
    localparam int WORDS = 3 * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pool_fmap_if #(.CONV_BIT(CB)) bus();

    pool_fmap_reader #(
        .CONV_BIT    (CB),
        .HALF_WIDTH  (HW),
        .HALF_HEIGHT (HH),
        .ADDR_BIT    (8),
        .CNT_BIT     (9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          gap;
        int          stall_at;
        bit          ovf_pulse;
        logic [11:0] base;
        bit          exp_ovf;
        int          exp_cycles;
    } vec_t;

    vec_t tab[5];

    int total = 0;
    int bad   = 0;
    int dut_xfer = 0;
    int dut_fd   = 0;

    // Reference model: a captured frame becomes a queue of 3N words.
    logic [11:0] m1 [N];
    logic [11:0] m2 [N];
    logic [11:0] m3 [N];
    logic [11:0] m_q [$];
    bit          m_filling;
    int          m_wr;
    bit          m_vout;
    logic [11:0] m_dout;
    bit          m_fd;
    bit          m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_filling = 1'b1;
        m_wr      = 0;
        m_vout    = 1'b0;
        m_dout    = '0;
        m_fd      = 1'b0;
        m_ovf     = 1'b0;
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance model one edge.
    task automatic cycle(input bit v, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input bit r);
        bit xfer;
        chk("valid_out", 32'(bus.valid_out), 32'(m_vout));
        if (m_vout) chk("data_out", 32'(bus.data_out), 32'(m_dout));
        chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (bus.frame_done === 1'b1) dut_fd++;
        bus.valid_in  = v;
        bus.data_in_1 = a;
        bus.data_in_2 = b;
        bus.data_in_3 = c;
        bus.ready_in  = r;
        if (bus.valid_out === 1'b1 && r) dut_xfer++;

        xfer = m_vout && r;
        m_fd = 1'b0;
        if (m_filling) begin
            if (v) begin
                m1[m_wr] = a;
                m2[m_wr] = b;
                m3[m_wr] = c;
                m_wr++;
                if (m_wr == N) begin
                    m_wr      = 0;
                    m_filling = 1'b0;
                    for (int i = 0; i < N; i++) m_q.push_back(m1[i]);
                    for (int i = 0; i < N; i++) m_q.push_back(m2[i]);
                    for (int i = 0; i < N; i++) m_q.push_back(m3[i]);
                end
            end
        end else begin
            if (v) m_ovf = 1'b1;
            if (xfer && m_q.size() == 0) begin
                m_vout    = 1'b0;
                m_fd      = 1'b1;
                m_filling = 1'b1;
            end else if ((!m_vout || r) && m_q.size() != 0) begin
                m_dout = m_q.pop_front();
                m_vout = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic fill_frame(input logic [11:0] base, input int gap);
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 12'(base + i), 12'(12'h100 + base + i), 12'(12'h200 + base + i), 1'b1);
            if (i != N - 1)
                for (int g = 0; g < gap; g++) cycle(1'b0, '0, '0, '0, 1'b1);
        end
    endtask

    task automatic run_frame(input vec_t t);
        int  n;
        int  stall_left;
        bit  stall_done;
        bit  tog;
        bit  r;
        bit  v;
        logic [11:0] d;
        fill_frame(t.base, t.gap);
        dut_xfer   = 0;
        n          = 0;
        stall_left = 5;
        stall_done = 1'b0;
        tog        = 1'b1;
        while (bus.frame_done !== 1'b1 && n < 3000) begin
            r = 1'b1;
            v = 1'b0;
            d = '0;
            if (t.stall_at >= 0) begin
                if (!stall_done) begin
                    if (dut_xfer == t.stall_at) begin
                        r = 1'b0;
                        chk("stall_hold", 32'(bus.data_out), 32'(12'(t.base + t.stall_at)));
                        stall_left--;
                        if (stall_left == 0) stall_done = 1'b1;
                    end
                end else begin
                    tog = ~tog;
                    r   = tog;
                end
            end
            if (t.ovf_pulse && n == 50) begin
                v = 1'b1;
                d = 12'hFFF;
            end
            cycle(v, d, d, d, r);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'd0, 32'd1);
        chk("xfers", 32'(dut_xfer), 32'(WORDS));
        chk("overflow_end", 32'(bus.overflow), 32'(t.exp_ovf));
        if (t.exp_cycles >= 0) chk("drain_cycles", 32'(n), 32'(t.exp_cycles));
    endtask

    initial begin
        int n;
        int fd_start;
        tab[0] = '{gap: 0, stall_at: -1, ovf_pulse: 1'b0, base: 12'h000, exp_ovf: 1'b0, exp_cycles: WORDS + 1};
        tab[1] = '{gap: 3, stall_at: -1, ovf_pulse: 1'b0, base: 12'h000, exp_ovf: 1'b0, exp_cycles: WORDS + 1};
        tab[2] = '{gap: 0, stall_at: 10, ovf_pulse: 1'b0, base: 12'h000, exp_ovf: 1'b0, exp_cycles: -1};
        tab[3] = '{gap: 0, stall_at: -1, ovf_pulse: 1'b1, base: 12'h000, exp_ovf: 1'b1, exp_cycles: WORDS + 1};
        tab[4] = '{gap: 0, stall_at: -1, ovf_pulse: 1'b0, base: 12'h040, exp_ovf: 1'b1, exp_cycles: WORDS + 1};

        bus.valid_in  = 1'b0;
        bus.data_in_1 = '0;
        bus.data_in_2 = '0;
        bus.data_in_3 = '0;
        bus.ready_in  = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) run_frame(tab[k]);

        // Asynchronous reset in the middle of a drain.
        fill_frame(12'h000, 0);
        dut_xfer = 0;
        n = 0;
        while (dut_xfer < 200 && n < 1000) begin
            cycle(1'b0, '0, '0, '0, 1'b1);
            n++;
        end
        if (n >= 1000) chk("mid_drain_timeout", 32'd0, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_data_out", 32'(bus.data_out), 32'd0);
        chk("async_valid_out", 32'(bus.valid_out), 32'd0);
        chk("async_frame_done", 32'(bus.frame_done), 32'd0);
        chk("async_overflow", 32'(bus.overflow), 32'd0);
        bus.valid_in = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(tab[0]);
        cycle(1'b0, '0, '0, '0, 1'b1);
        chk("fd_count", 32'(dut_fd), 32'd6);

        // Randomized traffic against the model: two complete frames.
        fd_start = dut_fd;
        n = 0;
        while (dut_fd < fd_start + 2 && n < 6000) begin
            cycle($urandom_range(0, 2) == 0, 12'($urandom), 12'($urandom), 12'($urandom),
                  $urandom_range(0, 3) != 0);
            n++;
        end
        if (n >= 6000) chk("random_timeout", 32'd0, 32'd1);
        cycle(1'b0, '0, '0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pool_fmap_reader.md
# pool_fmap_reader

Frame buffer and reader on the consuming side of the max-pool/ReLU stage. It captures the three-channel pooled stream (one pixel per `valid_in` pulse, raster order, HALF_WIDTH x HALF_HEIGHT pixels per frame) into three internal banks. Once a full frame is stored, it reads the frame back channel-major (all of channel 1, then channel 2, then channel 3) over a valid/ready handshake. The next layer (flatten / fully-connected) consumes that output.

## Interface
- `CONV_BIT`, 12: width of each pooled value (unsigned, post-ReLU).
- `HALF_WIDTH`, 12: pooled pixels per row.
- `HALF_HEIGHT`, 12: pooled rows per frame. N = HALF_WIDTH*HALF_HEIGHT.
- `ADDR_BIT`, 8: write/read pixel address width, must satisfy 2^ADDR_BIT >= N.
- `CNT_BIT`, 9: drain word counter width, must satisfy 2^CNT_BIT > 3N.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active low.
- `valid_in`  in  1  one pooled pixel present on `data_in_1..3`.
- `data_in_1`, `data_in_2`, `data_in_3`  in  CONV_BIT each  pooled values for channels 1, 2, 3.
- `ready_in`  in  1  downstream accepts `data_out` this cycle.
- `data_out`  out  CONV_BIT  current output word (registered).
- `valid_out`  out  1  `data_out` is valid (registered).
- `frame_done`  out  1  one-cycle pulse after the last word of a frame is accepted.
- `overflow`  out  1  sticky: a `valid_in` was dropped because the block was not in FILL.

## Operation
- Storage: three banks of N x CONV_BIT registers. A pixel is written to all three banks at address `wr_ptr`.
- States: FILL and DRAIN. Reset enters FILL with `wr_ptr`=0, `rd_cnt`=0.
- FILL behaviour:
  - Each edge with `valid_in`=1 writes the pixel at `wr_ptr`, then increments `wr_ptr`.
  - On the write with `wr_ptr`=N-1: `wr_ptr`<=0, `rd_cnt`<=0, state<=DRAIN.
  - Gaps between `valid_in` pulses of any length are allowed.
- DRAIN behaviour:
  - Load condition: (`valid_out`=0 or `ready_in`=1) and `rd_cnt` < 3N. When it holds, `data_out` <= bank[`rd_cnt`/N][`rd_cnt` mod N], `valid_out`<=1, `rd_cnt`++.
  - Implement the bank select and mod with a channel counter plus an address counter; no divider.
  - Handshake: a word transfers on an edge with `valid_out`=1 and `ready_in`=1.
  - While `valid_out`=1 and `ready_in`=0, `data_out` is held stable.
- End of frame: on the transfer edge of word 3N-1, with `rd_cnt`=3N:
  - `valid_out`<=0, `frame_done`<=1 for one cycle, state<=FILL, `rd_cnt`<=0.
- Overflow:
  - `valid_in`=1 sampled in DRAIN, including the final transfer edge, is dropped and sets `overflow`<=1.
  - `overflow` clears only on reset.
  - Dropped pixels never modify the banks or `wr_ptr`.
- Reset mid-operation: the frame is discarded and all state returns to reset values. Bank contents are don't-care after reset.

## Timing
- Reset values: `data_out`=0, `valid_out`=0, `frame_done`=0, `overflow`=0.
- The N-th pixel is written at edge E0, and DRAIN starts after E0.
- Edge E1: first word ch1[0] is loaded and `valid_out`=1.
- With `ready_in` held high, one word transfers per cycle.
- Word k is valid after edge E(k+1). The last word (ch3[N-1]) is accepted at E(3N+1).
- `frame_done` is high for exactly the cycle after E(3N+1).
- FILL accepts input from the edge after E(3N+1).
- Backpressure adds cycles one for one. No bubbles are inserted while `ready_in`=1.
- Defaults (N=144): 432 words per frame; minimum drain is 433 cycles from E0 to `frame_done`.

## Test plan
- Basic frame: 144 pixels back-to-back with ch1=i, ch2=0x100+i, ch3=0x200+i; `ready_in`=1 -> 432 words in order 0x000..0x08F, 0x100..0x18F, 0x200..0x28F. `frame_done` pulses once, in the cycle after the 432nd transfer. `overflow`=0.
- Sparse input: `valid_in` every 4th cycle, matching pooled cadence -> identical output sequence to the basic frame.
- Backpressure: hold `ready_in`=0 for 5 cycles at word 10, then toggle it every cycle -> `data_out` stays at 0x00A while stalled. No word is lost or duplicated.
- Overflow: pulse `valid_in` with 0xFFF during DRAIN -> `overflow`=1 and stays set. Output sequence unchanged. The next frame is written starting at address 0.
- Reset mid-drain: assert `rst_n`=0 after 200 words -> `valid_out`, `data_out`, `frame_done`, `overflow` go to 0 asynchronously. A subsequent full frame drains correctly from ch1[0].
- Back-to-back frames: second frame (values +0x40) starts on the first FILL cycle after `frame_done` -> the second drain carries the new values, and `frame_done` pulses twice in total.
